tt_eval_engine: RTL and testbench

- Parametrised, registered truth-table evaluator. Generalises the fixed 3-input gate netlists to N_IN inputs and N_CH independent output channels.
- Each channel's function is a runtime-programmable truth table.
- Input vectors are evaluated through a valid/ready pipeline stage with back-pressure.
- A built-in sweep FSM walks all 2^N_IN input combinations and captures the realised truth tables for readback. Used for self-characterisation against the designed hex code, e.g. 0x39.

---
 rtl/tt_eval_engine.sv | 120 ++++++++++++
 tb/tb_tt_eval_engine.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_eval_engine.sv
// Runtime-programmable truth-table evaluator with a registered output stage
// and a self-characterisation sweep that captures every channel's table.
module tt_eval_engine #(
    parameter int N_IN = 3,
    parameter int N_CH = 1,
    parameter logic [(1<<N_IN)-1:0] TT_RESET = '0,
    localparam int TT_W = 1 << N_IN,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [TT_W-1:0]      cfg_tt,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN-1:0]      in_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_CH-1:0]      out_vec,
    input  logic                 sweep_start,
    output logic                 sweep_busy,
    output logic                 sweep_done,
    output logic [N_CH*TT_W-1:0] sweep_result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RUN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [N_CH-1:0][TT_W-1:0] tbl;
    logic [N_CH-1:0][TT_W-1:0] res;
    logic [N_IN-1:0]           idx;
    logic [N_IN-1:0]           lk_idx;
    logic [N_CH-1:0]           lk;
    logic                      accept;
    logic                      cfg_ok;

    assign in_ready     = !sweep_busy && (!out_valid || out_ready);
    assign accept       = in_valid && in_ready;
    assign cfg_ok       = cfg_we && !sweep_busy;
    assign sweep_result = res;

    // The sweep borrows the evaluation lookup; input path is blocked then.
    assign lk_idx = (state == S_RUN) ? idx : in_vec;

    always_comb begin
        lk = '0;
        for (int c = 0; c < N_CH; c++) begin
            lk[c] = tbl[c][lk_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tbl <= {N_CH{TT_RESET}};
        end else if (cfg_ok) begin
            for (int c = 0; c < N_CH; c++) begin
                if (cfg_ch == CH_W'(c)) begin
                    tbl[c] <= cfg_tt;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_vec   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_vec   <= lk;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx <= '0;
            res <= '0;
        end else if (state == S_RUN) begin
            idx <= idx + N_IN'(1);
            for (int c = 0; c < N_CH; c++) begin
                res[c][idx] <= lk[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (sweep_start) state_nxt = S_WAIT;
            S_WAIT: if (!out_valid) state_nxt = S_RUN;
            S_RUN:  if (idx == N_IN'(TT_W - 1)) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        sweep_busy = (state != S_IDLE);
        sweep_done = (state == S_DONE);
    end

endmodule

// File: tb/tb_tt_eval_engine.sv
// Bench for tt_eval_engine: directed vectors, sweep corner cases and a
// randomized scoreboard run against a table-level reference model.
module tb_tt_eval_engine;

    localparam int N_IN = 3;
    localparam int N_CH = 3;
    localparam logic [7:0] TT_RST = 8'h5A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [7:0]  cfg_tt;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_vec;
    logic        sweep_start;
    logic        sweep_busy;
    logic        sweep_done;
    logic [23:0] sweep_result;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0] vec;
        logic [2:0] exp;
    } vec_t;

    vec_t       tv[6];
    logic [7:0] ref_tbl[3];
    logic [2:0] exp_q[$];

    tt_eval_engine #(
        .N_IN(N_IN),
        .N_CH(N_CH),
        .TT_RESET(TT_RST)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_tt(cfg_tt),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_vec(in_vec),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_vec(out_vec),
        .sweep_start(sweep_start),
        .sweep_busy(sweep_busy),
        .sweep_done(sweep_done),
        .sweep_result(sweep_result)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [7:0] tt);
        cfg_we = 1'b1;
        cfg_ch = ch;
        cfg_tt = tt;
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic wait_done(output int k_done);
        k_done = 0;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (sweep_done) begin
                k_done = k;
                break;
            end
        end
    endtask

    initial begin
        int         kd;
        logic       bad;
        logic [7:0] r;
        logic [2:0] e;
        logic       exp_rdy;

        tv[0] = '{vec: 3'd0, exp: 3'b001};
        tv[1] = '{vec: 3'd1, exp: 3'b110};
        tv[2] = '{vec: 3'd3, exp: 3'b111};
        tv[3] = '{vec: 3'd4, exp: 3'b111};
        tv[4] = '{vec: 3'd6, exp: 3'b110};
        tv[5] = '{vec: 3'd7, exp: 3'b000};

        rst_n = 1'b0;
        cfg_we = 1'b0;
        cfg_ch = '0;
        cfg_tt = '0;
        in_valid = 1'b0;
        in_vec = '0;
        out_ready = 1'b0;
        sweep_start = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_vec", 32'(out_vec), 0);
        check("rst_busy", 32'(sweep_busy), 0);
        check("rst_done", 32'(sweep_done), 0);
        check("rst_result", 32'(sweep_result), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // back-to-back lookups through the 0x39 table
        cfg(2'd0, 8'h39);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_vec = tv[i].vec;
            tick;
            check("t1_valid", 32'(out_valid), 1);
            check("t1_vec", 32'(out_vec), 32'(tv[i].exp));
        end
        in_valid = 1'b0;
        tick;
        check("t1_drain", 32'(out_valid), 0);

        // back-pressure holds the output register
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_vec = 3'd3;
        tick;
        in_vec = 3'd7;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("t2_in_ready", 32'(in_ready), 0);
            check("t2_hold_vec", 32'(out_vec), 32'(3'b111));
            check("t2_hold_valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        #1;
        check("t2_release_rdy", 32'(in_ready), 1);
        tick;
        check("t2_next_valid", 32'(out_valid), 1);
        check("t2_next_vec", 32'(out_vec), 32'(3'b000));
        in_valid = 1'b0;
        tick;
        check("t2_empty", 32'(out_valid), 0);

        // write and accept on the same edge: lookup sees the old table
        cfg_we = 1'b1;
        cfg_ch = 2'd0;
        cfg_tt = 8'hC6;
        in_valid = 1'b1;
        in_vec = 3'd0;
        tick;
        cfg_we = 1'b0;
        check("t3_old_tbl", 32'(out_vec[0]), 1);
        tick;
        check("t3_new_tbl", 32'(out_vec[0]), 0);
        in_valid = 1'b0;
        tick;

        // full sweep with empty pipeline; out-of-range channel write dropped
        cfg(2'd0, 8'h39);
        cfg(2'd1, 8'h96);
        cfg(2'd3, 8'hFF);
        tick;
        sweep_start = 1'b1;
        tick;
        sweep_start = 1'b0;
        check("t4_busy_t1", 32'(sweep_busy), 1);
        check("t4_rdy_t1", 32'(in_ready), 0);
        cfg_we = 1'b1;
        cfg_ch = 2'd0;
        cfg_tt = 8'h00;
        in_valid = 1'b1;
        in_vec = 3'd0;
        bad = 1'b0;
        kd = 0;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (in_ready || !sweep_busy || out_valid) bad = 1'b1;
            if (sweep_done) begin
                kd = k;
                break;
            end
        end
        cfg_we = 1'b0;
        in_valid = 1'b0;
        check("t4_blocked", 32'(bad), 0);
        check("t4_done_cycle", kd, 9);
        check("t4_result", 32'(sweep_result), 32'(24'h5A9639));
        tick;
        check("t4_idle_busy", 32'(sweep_busy), 0);
        check("t4_idle_done", 32'(sweep_done), 0);
        in_valid = 1'b1;
        in_vec = 3'd0;
        tick;
        check("t4_cfg_frozen", 32'(out_vec), 32'(3'b001));
        in_valid = 1'b0;
        tick;

        // sweep requested while an output is stalled
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_vec = 3'd1;
        tick;
        in_valid = 1'b0;
        sweep_start = 1'b1;
        tick;
        sweep_start = 1'b0;
        tick;
        tick;
        tick;
        check("t5_wait_busy", 32'(sweep_busy), 1);
        check("t5_wait_done", 32'(sweep_done), 0);
        check("t5_wait_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        tick;
        check("t5_drained", 32'(out_valid), 0);
        wait_done(kd);
        check("t5_done_cycle", kd, 9);
        check("t5_result", 32'(sweep_result), 32'(24'h5A9639));
        tick;

        // reset in the middle of RUN
        sweep_start = 1'b1;
        tick;
        sweep_start = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        rst_n = 1'b0;
        tick;
        check("t6_busy", 32'(sweep_busy), 0);
        check("t6_result", 32'(sweep_result), 0);
        check("t6_done", 32'(sweep_done), 0);
        check("t6_valid", 32'(out_valid), 0);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (sweep_done || sweep_busy) bad = 1'b1;
        end
        check("t6_no_pulse", 32'(bad), 0);
        r = TT_RST;
        for (int v = 0; v < 8; v++) begin
            in_valid = 1'b1;
            in_vec = 3'(v);
            tick;
            check("t6_reset_tbl", 32'(out_vec), 32'({3{r[v]}}));
        end
        in_valid = 1'b0;
        tick;

        // randomized traffic against a table-level scoreboard
        for (int c = 0; c < 3; c++) ref_tbl[c] = TT_RST;
        exp_q.delete();
        for (int n = 0; n < 400; n++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_vec = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cfg_we = ($urandom_range(0, 5) == 0);
            cfg_ch = 2'($urandom_range(0, 3));
            cfg_tt = 8'($urandom);
            #1;
            exp_rdy = (exp_q.size() == 0) || out_ready;
            check("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
            check("rnd_out_valid", 32'(out_valid),
                  32'(exp_q.size() != 0));
            if (out_valid && out_ready && exp_q.size() != 0) begin
                check("rnd_out_vec", 32'(out_vec), 32'(exp_q.pop_front()));
            end
            if (in_valid && exp_rdy) begin
                for (int c = 0; c < 3; c++) begin
                    r = ref_tbl[c];
                    e[c] = r[in_vec];
                end
                exp_q.push_back(e);
            end
            if (cfg_we && cfg_ch < 2'd3) ref_tbl[cfg_ch] = cfg_tt;
            tick;
        end
        in_valid = 1'b0;
        cfg_we = 1'b0;
        out_ready = 1'b1;
        tick;
        tick;
        exp_q.delete();
        sweep_start = 1'b1;
        tick;
        sweep_start = 1'b0;
        wait_done(kd);
        check("rnd_sweep_done", 32'(kd != 0), 1);
        check("rnd_sweep_result", 32'(sweep_result),
              32'({ref_tbl[2], ref_tbl[1], ref_tbl[0]}));
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
